// File: rtl/game_pkg.sv
// Shared 2048 game definitions: board geometry, tile exponents and the
// spawn sequencer state encoding reused by the game FSM and debug LEDs.
package game_pkg;

   localparam int CELLS = 16;
   localparam int IDX_W = 4;

   // log2 of the tile value written into the board
   localparam logic [1:0] EXP_2 = 2'd1;
   localparam logic [1:0] EXP_4 = 2'd2;

   typedef enum logic [2:0] {
      SPAWN_IDLE = 3'd0,
      SPAWN_TRY  = 3'd1,
      SPAWN_SCAN = 3'd2,
      SPAWN_DONE = 3'd3,
      SPAWN_FULL = 3'd4
   } spawn_state_t;

   // Map the xorshift coin bit onto a tile exponent (1 -> tile 2, 0 -> tile 4).
   function automatic logic [1:0] tile_exp_of(input logic two_or_four);
      logic [1:0] e;
      if (two_or_four) begin
         e = EXP_2;
      end else begin
         e = EXP_4;
      end
      return e;
   endfunction

   // Next cell index with natural wrap 15 -> 0.
   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      return idx + {{(IDX_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/tile_spawn_ctrl.sv
// Places one new tile after each move: random probing of a snapshotted
// occupancy map, falling back to a wrap-around linear probe, or reporting
// a full board. The random index input is named rand_idx because "rand"
// is a reserved word in SystemVerilog.
module tile_spawn_ctrl
   import game_pkg::*;
#(
   parameter int MAX_TRIES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             spawn_req,
   input  logic [CELLS-1:0] occupied,
   input  logic [IDX_W-1:0] rand_idx,
   input  logic             two_or_four,
   output logic             busy,
   output logic             spawn_valid,
   output logic [IDX_W-1:0] cell_idx,
   output logic [1:0]       tile_exp,
   output logic             board_full
);

   localparam logic [3:0]       LAST_TRY = 4'(MAX_TRIES - 1);
   localparam logic [CELLS-1:0] ALL_OCC  = {CELLS{1'b1}};

   spawn_state_t     state_r;
   logic [CELLS-1:0] occ_r;
   logic [3:0]       tries_r;
   logic [IDX_W-1:0] ptr_r;

   // Spawn sequencer: snapshot, random tries, linear probe, one-cycle result pulse.
   // The pulse cycle itself is IDLE with busy still set, so a request seen there
   // is ignored and a held request re-triggers one cycle later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= SPAWN_IDLE;
         occ_r       <= {CELLS{1'b0}};
         tries_r     <= 4'd0;
         ptr_r       <= {IDX_W{1'b0}};
         busy        <= 1'b0;
         spawn_valid <= 1'b0;
         board_full  <= 1'b0;
         cell_idx    <= {IDX_W{1'b0}};
         tile_exp    <= 2'd0;
      end else begin
         spawn_valid <= 1'b0;
         board_full  <= 1'b0;
         case (state_r)
            SPAWN_IDLE: begin
               if (spawn_req && !busy) begin
                  occ_r   <= occupied;
                  tries_r <= 4'd0;
                  busy    <= 1'b1;
                  if (occupied == ALL_OCC) begin
                     state_r <= SPAWN_FULL;
                  end else begin
                     state_r <= SPAWN_TRY;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            SPAWN_TRY: begin
               if (!occ_r[rand_idx]) begin
                  cell_idx <= rand_idx;
                  tile_exp <= tile_exp_of(two_or_four);
                  state_r  <= SPAWN_DONE;
               end else if (tries_r == LAST_TRY) begin
                  ptr_r   <= idx_inc(rand_idx);
                  state_r <= SPAWN_SCAN;
               end else begin
                  tries_r <= tries_r + 4'd1;
               end
            end
            SPAWN_SCAN: begin
               if (!occ_r[ptr_r]) begin
                  cell_idx <= ptr_r;
                  tile_exp <= tile_exp_of(two_or_four);
                  state_r  <= SPAWN_DONE;
               end else begin
                  ptr_r <= idx_inc(ptr_r);
               end
            end
            SPAWN_DONE: begin
               spawn_valid <= 1'b1;
               state_r     <= SPAWN_IDLE;
            end
            SPAWN_FULL: begin
               board_full <= 1'b1;
               state_r    <= SPAWN_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= SPAWN_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/tile_spawn_ctrl.md
Name: tile_spawn_ctrl

Overview:
Sequences the xorshift random unit to place one new tile on the 4x4 board after each move. On request it snapshots the board occupancy and tries random cell indices. After MAX_TRIES misses it falls back to a deterministic wrap-around probe. It then reports the chosen cell and tile exponent (2 or 4), or reports that the board is full. It sits between the game FSM (requester) and the board register file (consumer of the spawn write).

Parameters:
CELLS, 16, number of board cells; fixed at 16 for the 4x4 board.
IDX_W, 4, cell index width (log2 CELLS).
MAX_TRIES, 4, random attempts before falling back to the linear probe; legal range 1..15.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
spawn_req  input  1  start a spawn; sampled only in IDLE
occupied  input  CELLS  bit i = 1 when cell i holds a tile; snapshotted on accept
rand  input  IDX_W  random cell index from the xorshift unit; new value every clk
two_or_four  input  1  from the xorshift unit; 1 = tile 2, 0 = tile 4
busy  output  1  high from accept until the DONE/FULL cycle, inclusive
spawn_valid  output  1  one-cycle pulse; cell_idx/tile_exp valid
cell_idx  output  IDX_W  chosen empty cell
tile_exp  output  2  log2 of tile value: 1 = 2, 2 = 4
board_full  output  1  one-cycle pulse; no empty cell in snapshot, nothing spawned

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; busy, spawn_valid, board_full = 0; cell_idx = 0; tile_exp = 0; internal snapshot, try counter and probe pointer = 0. Reset mid-operation abandons the spawn with no pulse.
- All outputs are registered.
- States: IDLE, TRY, SCAN, DONE, FULL.
- IDLE:
  - If spawn_req = 1 at a clk edge: latch occupied into occ_q, clear tries.
  - Next state is FULL if occupied == all ones, else TRY.
  - busy goes high in the same edge.
- TRY, evaluated each cycle:
  - If occ_q[rand] = 0: cell_idx <= rand; tile_exp <= two_or_four ? 1 : 2; next state DONE.
  - Else if tries == MAX_TRIES-1: ptr <= rand+1 (mod 16, natural 4-bit wrap); next state SCAN.
  - Else tries <= tries+1; stay in TRY.
- SCAN, evaluated each cycle:
  - If occ_q[ptr] = 0: cell_idx <= ptr; tile_exp from two_or_four in that cycle; next state DONE.
  - Else ptr <= ptr+1 with wrap 15 -> 0.
  - Terminates within 15 cycles because the snapshot is known not full.
- DONE: spawn_valid = 1 for exactly one cycle; busy still 1; next state IDLE. cell_idx and tile_exp hold until the next spawn.
- FULL: board_full = 1 for exactly one cycle; busy 1; cell_idx/tile_exp unchanged; next state IDLE.
- Latency, counted in edges after the accepting edge N:
  - Best case: spawn_valid high after edge N+2.
  - Worst case: spawn_valid high after edge N+1+MAX_TRIES+15.
  - Full board: board_full high after edge N+1.
- Occupancy and handshake rules:
  - Changes to occupied while busy are ignored; the snapshot is used.
  - spawn_req while busy, or in the DONE/FULL cycle, is ignored and not queued.
  - spawn_req held high re-triggers on the first IDLE cycle after DONE/FULL.
- spawn_valid and board_full are never high together.

Decomposition:
- Shared package (game_pkg):
  - CELLS, IDX_W
  - tile exponent constants EXP_2 = 2'd1, EXP_4 = 2'd2
  - spawn state encoding, which the game FSM and debug LEDs reuse
- One natural sub-module: none required. The probe is a single mux-and-increment and stays inline. The xorshift unit is instantiated by the parent, not inside this block.

Test Plan:
- Empty board (occupied = 16'h0000), req, rand = 4'd9, two_or_four = 1 -> spawn_valid after edge N+2, cell_idx = 9, tile_exp = 1, busy low the cycle after.
- occupied = 16'h0200, rand sequence 9, 3, two_or_four = 0 at the hit -> hit on second try, cell_idx = 3, tile_exp = 2, spawn_valid after edge N+3.
- occupied = 16'hFFFE, rand held at 4'd5 -> 4 misses, SCAN from 6 wraps through 15 to 0; cell_idx = 0; spawn_valid after edge N+16.
- occupied = 16'hFFFF, req -> board_full pulse after edge N+1, spawn_valid stays 0, cell_idx unchanged.
- Board change and ignored request: occupied changed to 16'hFFFF one cycle after accept (snapshot 16'h0000), plus a spawn_req pulse while busy -> spawn still completes on snapshot, exactly one spawn_valid, no second spawn.
- Reset mid-op: assert rst = 0 while in SCAN -> all outputs 0 immediately (asynchronous), no pulse after release, next req behaves as from power-up.
